// File: rtl/dcache_pkg.sv
// Shared types and helpers for the store-forwarding read buffer.
// Width-generic helpers work on maximum widths; callers zero-extend in and truncate out.
package dcache_pkg;

  localparam int MAX_AW = 64;
  localparam int MAX_DW = 512;
  localparam int MAX_NB = MAX_DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESP_HIT,
    MEM_REQ,
    MEM_WAIT
  } rd_state_t;

  function automatic logic is_uncached(input logic [MAX_AW-1:0] addr,
                                       input logic [MAX_AW-1:0] mask,
                                       input logic [MAX_AW-1:0] match);
    return (addr & mask) == match;
  endfunction

  // Byte b of the result is upd[b] where sel[b] is set, otherwise base[b].
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] base,
                                                   input logic [MAX_DW-1:0] upd,
                                                   input logic [MAX_NB-1:0] sel);
    logic [MAX_DW-1:0] r;
    r = base;
    for (int b = 0; b < MAX_NB; b++) begin
      if (sel[b]) r[b*8 +: 8] = upd[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_entry_table.sv
// DEPTH-entry word table with byte-valid masks; round-robin allocation, merge, invalidate, flush.
// Lookups are combinational; updates land on the next edge; never backpressures.
module fwd_entry_table #(
  parameter int DEPTH  = 8,
  parameter int WA_W   = 30,
  parameter int DATA_W = 32,
  parameter int NB     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [WA_W-1:0]   rd_waddr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [NB-1:0]     rd_bm,
  input  logic [WA_W-1:0]   wl_waddr,
  output logic              wl_hit,
  output logic [DATA_W-1:0] wl_data,
  output logic [NB-1:0]     wl_bm,
  input  logic              wr_en,
  input  logic              wr_uc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_bm
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid;
  logic [WA_W-1:0]   tag  [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [NB-1:0]     bm   [DEPTH];
  logic [IW-1:0]     wptr;
  logic [IW-1:0]     wl_idx;

  // At most one entry can match, so last-match-wins is a plain one-hot select.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    rd_bm   = '0;
    wl_hit  = 1'b0;
    wl_data = '0;
    wl_bm   = '0;
    wl_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag[i] == rd_waddr) begin
        rd_hit  = 1'b1;
        rd_data = data[i];
        rd_bm   = bm[i];
      end
      if (valid[i] && tag[i] == wl_waddr) begin
        wl_hit  = 1'b1;
        wl_data = data[i];
        wl_bm   = bm[i];
        wl_idx  = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= '0;
      wptr  <= '0;
    end else if (flush) begin
      valid <= '0;
      wptr  <= '0;
    end else if (wr_en) begin
      if (wr_uc) begin
        if (wl_hit) valid[wl_idx] <= 1'b0;
      end else if (wl_hit) begin
        data[wl_idx] <= wr_data;
        bm[wl_idx]   <= wr_bm;
      end else begin
        valid[wptr] <= 1'b1;
        tag[wptr]   <= wl_waddr;
        data[wptr]  <= wr_data;
        bm[wptr]    <= wr_bm;
        wptr        <= wptr + IW'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_fwd_buffer.sv
// Store-forwarding read buffer: full hits answered locally, partial hits overlay memory data.
// Hit response 2 cycles after accept, miss request 2 cycles after accept; one read in flight.
module dcache_fwd_buffer
  import dcache_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] UC_MASK  = 32'hFFFF0000,
  parameter logic [ADDR_W-1:0] UC_MATCH = 32'hFFFF0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rvalid,
  input  logic                s_rready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  input  logic                flush,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int NB   = DATA_W / 8;
  localparam int OFF  = (NB > 1) ? $clog2(NB) : 0;
  localparam int WA_W = ADDR_W - OFF;

  rd_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] snap_data;
  logic [NB-1:0]     snap_bm;
  logic              rsp_hit;

  logic              wr_ev, wr_uc, stall;
  logic [WA_W-1:0]   wr_waddr, rd_waddr;
  logic              rd_hit, wl_hit, rd_uc, full_hit;
  logic [DATA_W-1:0] rd_data, wl_data, wr_data;
  logic [NB-1:0]     rd_bm, wl_bm, wr_bm;

  assign wr_ev    = s_awvalid & s_wvalid;
  assign wr_waddr = s_awaddr[ADDR_W-1:OFF];
  assign rd_waddr = addr_q[ADDR_W-1:OFF];
  assign wr_uc    = is_uncached(MAX_AW'(s_awaddr), MAX_AW'(UC_MASK), MAX_AW'(UC_MATCH));
  assign rd_uc    = is_uncached(MAX_AW'(addr_q), MAX_AW'(UC_MASK), MAX_AW'(UC_MATCH));
  assign wr_data  = wl_hit ? DATA_W'(byte_merge(MAX_DW'(wl_data), MAX_DW'(s_wdata), MAX_NB'(s_wstrb)))
                           : s_wdata;
  assign wr_bm    = wl_bm | s_wstrb;
  assign stall    = wr_ev & (wr_waddr == rd_waddr);
  assign full_hit = rd_hit & ~rd_uc & (&rd_bm);

  fwd_entry_table #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W),
    .NB     (NB)
  ) u_table (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .rd_waddr (rd_waddr),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .rd_bm    (rd_bm),
    .wl_waddr (wr_waddr),
    .wl_hit   (wl_hit),
    .wl_data  (wl_data),
    .wl_bm    (wl_bm),
    .wr_en    (wr_ev & (|s_wstrb)),
    .wr_uc    (wr_uc),
    .wr_data  (wr_data),
    .wr_bm    (wr_bm)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      s_arready <= 1'b1;
      m_arvalid <= 1'b0;
      rsp_hit   <= 1'b0;
      addr_q    <= '0;
      snap_data <= '0;
      snap_bm   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_arvalid) begin
            addr_q    <= s_araddr;
            s_arready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          // A same-word write would race the snapshot; retry once the table settles.
          if (!stall) begin
            snap_data <= rd_data;
            snap_bm   <= (rd_hit & ~rd_uc) ? rd_bm : '0;
            if (full_hit) begin
              rsp_hit <= 1'b1;
              state   <= RESP_HIT;
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
              m_arvalid <= 1'b1;
              state     <= MEM_REQ;
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        RESP_HIT: begin
          if (s_rready) begin
            rsp_hit   <= 1'b0;
            s_arready <= 1'b1;
            state     <= IDLE;
          end
        end
        MEM_REQ: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (m_rvalid && s_rready) begin
            s_arready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          s_arready <= 1'b1;
          m_arvalid <= 1'b0;
          rsp_hit   <= 1'b0;
        end
      endcase
    end
  end

  assign m_araddr = addr_q;
  assign s_rvalid = rsp_hit | ((state == MEM_WAIT) & m_rvalid);
  assign m_rready = (state == MEM_WAIT) & s_rready;
  assign s_rdata  = (state == MEM_WAIT)
                  ? DATA_W'(byte_merge(MAX_DW'(m_rdata), MAX_DW'(snap_data), MAX_NB'(snap_bm)))
                  : snap_data;

endmodule
